phy_tx_sched: RTL and testbench
===============================

PHY_TX_SCHED -- requirements
Module: phy_tx_sched

Interface
REQ-001 Parameter SYNC_CYCLES, default 4, SHALL set the number of sync cycles before the first grant (range 1..255).
REQ-002 Parameter MAX_BURST, default 4, SHALL set the maximum consecutive grants to one requester while the other is pending (range 1..255).
REQ-003 Port clk_f  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 Port enable  input  1  SHALL be the link enable; 1 = schedule traffic, 0 = go idle.
REQ-006 Ports req0_valid / req1_valid  input  1  SHALL flag a word offered by requester 0 / 1.
REQ-007 Ports req0_data / req1_data  input  32  SHALL carry the offered word.
REQ-008 Ports req0_ready / req1_ready  output  1  SHALL flag acceptance; a transfer occurs on an edge where valid and ready are both 1.
REQ-009 Port data_in  output  32  SHALL be the registered word driven to the PHY TX.
REQ-010 Port valid_in  output  1  SHALL be the registered valid qualifier for data_in.
REQ-011 Port state  output  2  SHALL expose the FSM state: IDLE=00, SYNC=01, ACTIVE=10.

Function
REQ-012 IDLE: no grants; on a clock edge with enable=1, the FSM SHALL move to SYNC with the sync counter cleared.
REQ-013 SYNC: no grants; the counter increments each cycle, and the FSM SHALL move to ACTIVE on the edge where the counter reaches SYNC_CYCLES-1 (exactly SYNC_CYCLES cycles in SYNC).
REQ-014 SYNC or ACTIVE with enable=0: the FSM SHALL move to IDLE on the next edge; a later enable=1 SHALL always pass through SYNC again.
REQ-015 ready SHALL be combinational, asserted only in ACTIVE, and asserted for at most one requester per cycle (the grant).
REQ-016 With only one requester valid, the grant SHALL go to that requester.
REQ-017 With both valid, the grant SHALL go to the current owner, unless burst_cnt equals MAX_BURST, in which case it goes to the other requester.
REQ-018 On a transfer to the owner, burst_cnt SHALL increment (saturating at MAX_BURST).
REQ-019 On a transfer to the non-owner, owner SHALL become the granted requester and burst_cnt SHALL become 1.
REQ-020 Latency: a word accepted at edge k SHALL appear on data_in with valid_in=1 during the cycle after edge k, i.e. one cycle.
REQ-021 On cycles with no transfer at the preceding edge, valid_in SHALL be 0 and data_in SHALL take the idle value (REQ-028/029).
REQ-022 There is no backpressure from the PHY; back-to-back transfers on every cycle SHALL be sustained.
REQ-023 If enable falls in the same cycle as a grant, that transfer SHALL complete and its word SHALL be output; no further grants are issued.
REQ-024 Neither valid in ACTIVE: no ready is asserted, and owner and burst_cnt SHALL hold.

Reset
REQ-025 While reset=1, the block SHALL asynchronously force state=IDLE, sync counter=0, owner=0, burst_cnt=0, data_in=0, valid_in=0, req0_ready=0 and req1_ready=0.
REQ-026 Reset mid-burst SHALL discard any word in flight; after release, operation SHALL resume from IDLE per REQ-012.
REQ-027 The first edge after reset release with enable=1 SHALL enter SYNC.

Configuration
REQ-028 With PHY_TX_SCHED_IDLE_PATTERN_EN defined, data_in SHALL drive 32'hBCBCBCBC on every non-valid cycle in SYNC and ACTIVE, and 0 in IDLE and during reset.
REQ-029 Without PHY_TX_SCHED_IDLE_PATTERN_EN, data_in SHALL be 0 on every non-valid cycle.

Verification
REQ-030 Reset then enable=1 with both valid=0: state SHALL read 01 for exactly 4 cycles, then 10; no ready is asserted; with the macro defined, data_in=BCBCBCBC during SYNC.
REQ-031 In ACTIVE, req0 offers FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC back-to-back, req1 idle: valid_in SHALL be 1 for 4 consecutive cycles with the same data, each one cycle after acceptance.
REQ-032 Both requesters hold valid continuously, req0 data=3, req1 data=4, MAX_BURST=4: the output sequence SHALL be 3,3,3,3,4,4,4,4,3,...
REQ-033 Drop enable during the third word of a burst: that word SHALL be output, ready SHALL be 0 afterwards, and state SHALL be 00; re-enable SHALL give 4 SYNC cycles before the next grant.
REQ-034 Assert reset asynchronously (between edges) mid-burst: valid_in and both ready signals SHALL be 0 immediately, and the in-flight word SHALL never appear.
REQ-035 Repeat REQ-030 with the macro undefined: data_in SHALL be 0 throughout SYNC and idle ACTIVE cycles.

Source files
------------

// File: rtl/phy_tx_sched.sv
// Two-requester transmit scheduler feeding a PHY: IDLE -> SYNC -> ACTIVE link FSM with burst-limited arbitration.
// Optional macro PHY_TX_SCHED_IDLE_PATTERN_EN: drive 32'hBCBCBCBC on non-valid SYNC/ACTIVE cycles instead of 0.
module phy_tx_sched #(
    parameter int unsigned SYNC_CYCLES = 4,
    parameter int unsigned MAX_BURST   = 4
) (
    input  logic        clk_f,
    input  logic        reset,
    input  logic        enable,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic [31:0] data_in,
    output logic        valid_in,
    output logic [1:0]  state
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;

`ifdef PHY_TX_SCHED_IDLE_PATTERN_EN
    localparam logic [DW-1:0] IDLE_WORD = 32'hBCBC_BCBC;
`else
    localparam logic [DW-1:0] IDLE_WORD = 32'h0000_0000;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SYNC   = 2'b01,
        ST_ACTIVE = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   sync_cnt_q, sync_cnt_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
    logic            owner_q, owner_d;
    logic [DW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;

    logic            gnt0, gnt1, pick1, xfer;

    // State register
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; enable low always returns to IDLE so re-enable resyncs
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (!enable)                                   state_d = ST_IDLE;
                else if (sync_cnt_q == CW'(SYNC_CYCLES - 1))   state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant, arbitration bookkeeping and output word selection
    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        pick1       = 1'b0;
        xfer        = 1'b0;
        sync_cnt_d  = '0;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        valid_d     = 1'b0;
        data_d      = '0;

        if (state_q == ST_SYNC && state_d == ST_SYNC) begin
            sync_cnt_d = sync_cnt_q + CW'(1);
        end

        // Contention keeps the owner until its burst limit, then hands over
        if (req0_valid && req1_valid) begin
            pick1 = (burst_cnt_q == CW'(MAX_BURST)) ? !owner_q : owner_q;
        end else begin
            pick1 = req1_valid;
        end

        if (state_q == ST_ACTIVE) begin
            gnt0 = req0_valid && !pick1;
            gnt1 = req1_valid && pick1;
        end
        xfer = gnt0 || gnt1;

        if (xfer) begin
            if (pick1 == owner_q) begin
                burst_cnt_d = (burst_cnt_q == CW'(MAX_BURST)) ? burst_cnt_q
                                                              : burst_cnt_q + CW'(1);
            end else begin
                owner_d     = pick1;
                burst_cnt_d = CW'(1);
            end
        end

        valid_d = xfer;
        if (xfer) begin
            data_d = gnt1 ? req1_data : req0_data;
        end else if (state_d != ST_IDLE) begin
            data_d = IDLE_WORD;
        end
    end

    // Datapath and arbitration registers
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            sync_cnt_q  <= '0;
            burst_cnt_q <= '0;
            owner_q     <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            sync_cnt_q  <= sync_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            owner_q     <= owner_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign data_in    = data_q;
    assign valid_in   = valid_q;
    assign state      = state_q;

endmodule

// File: tb/tb_phy_tx_sched.sv
// Self-checking bench for phy_tx_sched: directed scenarios plus randomized traffic against a reference model.
module tb_phy_tx_sched;

    localparam int unsigned SYNC_N  = 4;
    localparam int unsigned BURST_N = 4;
`ifdef PHY_TX_SCHED_IDLE_PATTERN_EN
    localparam logic [31:0] IDLE_EXP = 32'hBCBC_BCBC;
`else
    localparam logic [31:0] IDLE_EXP = 32'h0000_0000;
`endif

    logic        clk_f = 1'b0;
    logic        reset;
    logic        enable;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [31:0] data_in;
    logic        valid_in;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    // Reference model state: link phase, remaining sync cycles, arbitration owner and run length
    int m_phase;
    int m_left;
    int m_owner;
    int m_burst;

    phy_tx_sched #(.SYNC_CYCLES(SYNC_N), .MAX_BURST(BURST_N)) dut (
        .clk_f      (clk_f),
        .reset      (reset),
        .enable     (enable),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .state      (state)
    );

    always #5 clk_f = ~clk_f;

    // Reset the DUT and bring it to ACTIVE; leaves time at posedge+1 with owner 0, run length 0
    task automatic reset_and_sync();
        reset = 1'b1; enable = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        @(posedge clk_f); #1;
        reset = 1'b0; enable = 1'b1;
        repeat (SYNC_N + 1) @(posedge clk_f);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 32'h1111_1111; req1_data = 32'h2222_2222;
        #1;
        checks++;
        if (state !== 2'b00 || valid_in !== 1'b0 || data_in !== 32'h0 ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: state=%b valid=%b data=%h rdy=%b%b, required 00/0/0/00",
                     state, valid_in, data_in, req0_ready, req1_ready);
        end
        enable = 1'b1;
        @(posedge clk_f); #1;
        checks++;
        if (state !== 2'b00 || valid_in !== 1'b0 || data_in !== 32'h0) begin
            errors++;
            $display("FAIL reset_held: state=%b valid=%b data=%h, required 00/0/0", state, valid_in, data_in);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; enable = 1'b0;
    endtask

    task automatic test_sync();
        reset = 1'b0; enable = 1'b1;
        for (int i = 0; i < int'(SYNC_N); i++) begin
            @(posedge clk_f); #1;
            checks++;
            if (state !== 2'b01 || valid_in !== 1'b0 || data_in !== IDLE_EXP ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL sync_cycle%0d: state=%b valid=%b data=%h rdy=%b%b, required 01/0/%h/00",
                         i, state, valid_in, data_in, req0_ready, req1_ready, IDLE_EXP);
            end
        end
        @(posedge clk_f); #1;
        checks++;
        if (state !== 2'b10 || valid_in !== 1'b0 || data_in !== IDLE_EXP ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL sync_to_active: state=%b valid=%b data=%h rdy=%b%b, required 10/0/%h/00",
                     state, valid_in, data_in, req0_ready, req1_ready, IDLE_EXP);
        end
    endtask

    task automatic test_single_burst();
        logic [31:0] words [4];
        words[0] = 32'hFFFF_FFFF; words[1] = 32'hEEEE_EEEE;
        words[2] = 32'hDDDD_DDDD; words[3] = 32'hCCCC_CCCC;
        req0_valid = 1'b1; req0_data = words[0];
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL burst_ready0: rdy=%b%b, required 10", req0_ready, req1_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_f); #1;
            checks++;
            if (valid_in !== 1'b1 || data_in !== words[i]) begin
                errors++;
                $display("FAIL burst_word%0d: valid=%b data=%h, required 1/%h", i, valid_in, data_in, words[i]);
            end
            if (i < 3) req0_data = words[i+1];
            else       req0_valid = 1'b0;
            #1;
            checks++;
            if (req0_ready !== (i < 3) || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL burst_ready%0d: rdy=%b%b, required %b0", i + 1, req0_ready, req1_ready, i < 3);
            end
        end
        @(posedge clk_f); #1;
        checks++;
        if (valid_in !== 1'b0 || data_in !== IDLE_EXP) begin
            errors++;
            $display("FAIL burst_tail: valid=%b data=%h, required 0/%h", valid_in, data_in, IDLE_EXP);
        end
    endtask

    task automatic test_alternation();
        logic [31:0] exp;
        reset_and_sync();
        req0_valid = 1'b1; req0_data = 32'd3;
        req1_valid = 1'b1; req1_data = 32'd4;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_f); #1;
            exp = (((i / int'(BURST_N)) % 2) == 0) ? 32'd3 : 32'd4;
            checks++;
            if (valid_in !== 1'b1 || data_in !== exp) begin
                errors++;
                $display("FAIL alternate_word%0d: valid=%b data=%0d, required 1/%0d", i, valid_in, data_in, exp);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic [31:0] w [3];
        w[0] = 32'hA000_0001; w[1] = 32'hA000_0002; w[2] = 32'hA000_0003;
        reset_and_sync();
        req0_valid = 1'b1; req0_data = w[0];
        @(posedge clk_f); #1;
        req0_data = w[1];
        @(posedge clk_f); #1;
        req0_data = w[2]; enable = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_last_grant: ready0=%b, required 1", req0_ready);
        end
        @(posedge clk_f); #1;
        checks++;
        if (valid_in !== 1'b1 || data_in !== w[2] || state !== 2'b00 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL drop_flush: valid=%b data=%h state=%b ready0=%b, required 1/%h/00/0",
                     valid_in, data_in, state, req0_ready, w[2]);
        end
        @(posedge clk_f); #1;
        checks++;
        if (valid_in !== 1'b0 || data_in !== 32'h0 || state !== 2'b00) begin
            errors++;
            $display("FAIL drop_idle: valid=%b data=%h state=%b, required 0/0/00", valid_in, data_in, state);
        end
        enable = 1'b1;
        for (int i = 0; i < int'(SYNC_N); i++) begin
            @(posedge clk_f); #1;
            checks++;
            if (state !== 2'b01 || req0_ready !== 1'b0 || valid_in !== 1'b0) begin
                errors++;
                $display("FAIL resync_cycle%0d: state=%b ready0=%b valid=%b, required 01/0/0",
                         i, state, req0_ready, valid_in);
            end
        end
        @(posedge clk_f); #1;
        checks++;
        if (state !== 2'b10 || req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL resync_grant: state=%b ready0=%b, required 10/1", state, req0_ready);
        end
        req0_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [31:0] x_word;
        x_word = 32'h5A5A_0BAD;
        reset_and_sync();
        req0_valid = 1'b1; req0_data = 32'h0000_1234;
        @(posedge clk_f); #1;
        req0_data = x_word;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (valid_in !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
            state !== 2'b00 || data_in !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: valid=%b rdy=%b%b state=%b data=%h, required 0/00/00/0",
                     valid_in, req0_ready, req1_ready, state, data_in);
        end
        req0_valid = 1'b0;
        @(posedge clk_f); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_f); #1;
            checks++;
            if (valid_in !== 1'b0 || data_in === x_word || state !== 2'b01) begin
                errors++;
                $display("FAIL post_reset%0d: valid=%b data=%h state=%b, required 0/not %h/01",
                         i, valid_in, data_in, state, x_word);
            end
        end
    endtask

    // Model grant: -1 none, 0 or 1 requester index
    function automatic int model_grant(input logic v0, input logic v1);
        if (m_phase != 2)  return -1;
        if (v0 && v1)      return (m_burst == int'(BURST_N)) ? 1 - m_owner : m_owner;
        if (v0)            return 0;
        if (v1)            return 1;
        return -1;
    endfunction

    task automatic test_random();
        int          g;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [1:0]  exp_state;
        reset = 1'b1; enable = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk_f); #1;
        reset = 1'b0;
        m_phase = 0; m_left = 0; m_owner = 0; m_burst = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            enable     = ($urandom_range(0, 15) != 0);
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_data  = $urandom;
            req1_data  = $urandom;
            #1;
            g = model_grant(req0_valid, req1_valid);
            checks++;
            if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
                errors++;
                $display("FAIL rand_ready cyc%0d: rdy=%b%b, required %b%b",
                         cyc, req0_ready, req1_ready, g == 0, g == 1);
            end
            exp_valid = (g >= 0);
            exp_data  = (g == 0) ? req0_data : (g == 1) ? req1_data : 32'h0;
            case (m_phase)
                0: if (enable) begin m_phase = 1; m_left = int'(SYNC_N); end
                1: if (!enable) m_phase = 0;
                   else begin
                       m_left--;
                       if (m_left == 0) m_phase = 2;
                   end
                default: if (!enable) m_phase = 0;
            endcase
            if (g >= 0) begin
                if (g == m_owner) m_burst = (m_burst < int'(BURST_N)) ? m_burst + 1 : m_burst;
                else begin m_owner = g; m_burst = 1; end
            end
            if (!exp_valid && m_phase != 0) exp_data = IDLE_EXP;
            exp_state = 2'(m_phase);
            @(posedge clk_f); #1;
            checks++;
            if (valid_in !== exp_valid || data_in !== exp_data || state !== exp_state) begin
                errors++;
                $display("FAIL rand_out cyc%0d: valid=%b data=%h state=%b, required %b/%h/%b",
                         cyc, valid_in, data_in, state, exp_valid, exp_data, exp_state);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0; enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sync();
        test_single_burst();
        test_alternation();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
